namuru_time_base: RTL and testbench

Programmable time base for the Namuru GPS correlator, in the `gps_rec_clk` domain directly upstream of the correlator channels and the bus bridge. It counts front-end sample strobes and produces the two system timing pulses:
- `tic_enable`: the measurement TIC, which latches code/carrier phases.
- `accum_enable`: the accumulation dump.

It also raises a sticky accumulation interrupt for software, which the bus bridge reads and clears.

---
 rtl/namuru_pkg.sv | 15 +
 rtl/namuru_div_counter.sv | 63 ++++++
 rtl/namuru_time_base.sv | 96 +++++++++
 tb/tb_namuru_time_base.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/namuru_pkg.sv
// namuru_pkg
// Shared definitions for the Namuru time base.
//   TIC_W_DEF / ACCUM_W_DEF : default divider/counter widths
//   DIV_RST_ALL             : all-ones reset pattern. Each user slices this
//                             pattern to its own width to get the divider
//                             and counter reset value.
package namuru_pkg;

  localparam int TIC_W_DEF   = 24;
  localparam int ACCUM_W_DEF = 24;

  // Wide enough for any supported counter width (up to 64 bits)
  localparam logic [63:0] DIV_RST_ALL = {64{1'b1}};

endpackage : namuru_pkg

// File: rtl/namuru_div_counter.sv
// namuru_div_counter
// Reloading down-counter with a shadow divider register and a registered
// one-cycle pulse output.
//   i_clk        : clock
//   i_rst_n      : asynchronous active-low reset
//   i_sample_en  : the counter advances only when this is high
//   i_cfg_load   : captures i_divide into the shadow register and the counter.
//                  It has priority over counting and suppresses the pulse.
//   i_divide     : new divider value, used only while i_cfg_load is high
//   o_pulse      : one-cycle pulse, one cycle after a sample taken at count 0
//   o_count      : live counter value
module namuru_div_counter
  import namuru_pkg::*;
#(
  parameter int W = TIC_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_sample_en,
  input  logic         i_cfg_load,
  input  logic [W-1:0] i_divide,
  output logic         o_pulse,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] RST_VAL = DIV_RST_ALL[W-1:0];
  localparam logic [W-1:0] ONE     = W'(1'b1);

  logic [W-1:0] r_div_q;
  logic [W-1:0] r_count;
  logic         r_pulse;
  logic         w_zero;

  assign w_zero = (r_count == {W{1'b0}});

  // Shadow divider, counter and pulse register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_q <= RST_VAL;
      r_count <= RST_VAL;
      r_pulse <= 1'b0;
    end else if (i_cfg_load) begin
      // A load restarts the period, so a pending zero-count sample is dropped
      r_div_q <= i_divide;
      r_count <= i_divide;
      r_pulse <= 1'b0;
    end else if (i_sample_en) begin
      if (w_zero) begin
        r_count <= r_div_q;
        r_pulse <= 1'b1;
      end else begin
        r_count <= r_count - ONE;
        r_pulse <= 1'b0;
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;
  assign o_count = r_count;

endmodule : namuru_div_counter

// File: rtl/namuru_time_base.sv
// namuru_time_base
// Time base for the Namuru GPS correlator. It counts front-end sample strobes
// and produces the measurement TIC pulse and the accumulation dump pulse. It
// also holds the sticky accumulation interrupt flags.
//   gps_rec_clk  : receiver sample clock
//   sys_rst_n    : asynchronous active-low reset
//   sample_en    : one-cycle strobe per valid sample
//   tic_divide   : TIC period minus one, in samples (captured on cfg_load)
//   accum_divide : accumulation period minus one, in samples (captured on cfg_load)
//   cfg_load     : captures both dividers and restarts both counters
//   int_clear    : clears accum_int and int_overrun
//   tic_enable   : one-cycle TIC pulse
//   accum_enable : one-cycle accumulation dump pulse
//   accum_int    : sticky, set by every dump
//   int_overrun  : sticky, set when a dump arrives while accum_int is set
//   tic_count    : live TIC down-counter
// Build option: when NAMURU_ACCUM_INT_EN is defined, the interrupt flags are
// built. Otherwise both flags read 0 and int_clear is ignored.
module namuru_time_base
  import namuru_pkg::*;
#(
  parameter int TIC_W   = TIC_W_DEF,
  parameter int ACCUM_W = ACCUM_W_DEF
) (
  input  logic               gps_rec_clk,
  input  logic               sys_rst_n,
  input  logic               sample_en,
  input  logic [TIC_W-1:0]   tic_divide,
  input  logic [ACCUM_W-1:0] accum_divide,
  input  logic               cfg_load,
  input  logic               int_clear,
  output logic               tic_enable,
  output logic               accum_enable,
  output logic               accum_int,
  output logic               int_overrun,
  output logic [TIC_W-1:0]   tic_count
);

  logic [ACCUM_W-1:0] w_accum_count_unused;

  namuru_div_counter #(.W(TIC_W)) u_tic (
    .i_clk       (gps_rec_clk),
    .i_rst_n     (sys_rst_n),
    .i_sample_en (sample_en),
    .i_cfg_load  (cfg_load),
    .i_divide    (tic_divide),
    .o_pulse     (tic_enable),
    .o_count     (tic_count)
  );

  namuru_div_counter #(.W(ACCUM_W)) u_accum (
    .i_clk       (gps_rec_clk),
    .i_rst_n     (sys_rst_n),
    .i_sample_en (sample_en),
    .i_cfg_load  (cfg_load),
    .i_divide    (accum_divide),
    .o_pulse     (accum_enable),
    .o_count     (w_accum_count_unused)
  );

`ifdef NAMURU_ACCUM_INT_EN
  logic r_accum_int;
  logic r_int_overrun;

  // Sticky interrupt flags. A dump wins over a clear in the same cycle.
  always_ff @(posedge gps_rec_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_accum_int   <= 1'b0;
      r_int_overrun <= 1'b0;
    end else if (accum_enable) begin
      r_accum_int <= 1'b1;
      // With a simultaneous clear, overrun keeps its current value
      if (r_accum_int && !int_clear) begin
        r_int_overrun <= 1'b1;
      end else begin
        r_int_overrun <= r_int_overrun;
      end
    end else if (int_clear) begin
      r_accum_int   <= 1'b0;
      r_int_overrun <= 1'b0;
    end else begin
      r_accum_int   <= r_accum_int;
      r_int_overrun <= r_int_overrun;
    end
  end

  assign accum_int   = r_accum_int;
  assign int_overrun = r_int_overrun;
`else
  logic w_unused_int_clear;
  assign w_unused_int_clear = int_clear;
  assign accum_int          = 1'b0;
  assign int_overrun        = 1'b0;
`endif

endmodule : namuru_time_base

// File: tb/tb_namuru_time_base.sv
module tb_namuru_time_base;

  localparam int TW = 8;
  localparam int AW = 8;
`ifdef NAMURU_ACCUM_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  logic          gps_rec_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [TW-1:0] tic_divide = '0;
  logic [AW-1:0] accum_divide = '0;
  logic          cfg_load = 1'b0;
  logic          int_clear = 1'b0;
  logic          tic_enable, accum_enable, accum_int, int_overrun;
  logic [TW-1:0] tic_count;

  int total = 0;
  int bad = 0;

  namuru_time_base #(.TIC_W(TW), .ACCUM_W(AW)) dut (
    .gps_rec_clk (gps_rec_clk),
    .sys_rst_n   (sys_rst_n),
    .sample_en   (sample_en),
    .tic_divide  (tic_divide),
    .accum_divide(accum_divide),
    .cfg_load    (cfg_load),
    .int_clear   (int_clear),
    .tic_enable  (tic_enable),
    .accum_enable(accum_enable),
    .accum_int   (accum_int),
    .int_overrun (int_overrun),
    .tic_count   (tic_count)
  );

  always #5 gps_rec_clk = ~gps_rec_clk;

  // Reference model: per unit, the period length D+1 and the number of
  // samples seen since the last restart. Index 0 = TIC, 1 = accumulation.
  int m_d[2];
  int m_k[2];
  bit m_en[2];
  bit m_int, m_ovr;

  task automatic model_reset();
    m_d[0] = (1 << TW) - 1;
    m_d[1] = (1 << AW) - 1;
    m_k[0] = 0; m_k[1] = 0;
    m_en[0] = 0; m_en[1] = 0;
    m_int = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit se, input bit ld, input bit clr, input int td, input int ad);
    if (INT_ON) begin
      if (m_en[1]) begin
        if (m_int && !clr) m_ovr = 1;
        m_int = 1;
      end else if (clr) begin
        m_int = 0; m_ovr = 0;
      end
    end
    for (int u = 0; u < 2; u++) begin
      m_en[u] = 0;
      if (ld) begin
        m_d[u] = (u == 0) ? td : ad;
        m_k[u] = 0;
      end else if (se) begin
        m_k[u] = m_k[u] + 1;
        if (m_k[u] == m_d[u] + 1) begin
          m_k[u] = 0;
          m_en[u] = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("tic_enable", int'(tic_enable), int'(m_en[0]));
    check("accum_enable", int'(accum_enable), int'(m_en[1]));
    check("accum_int", int'(accum_int), int'(m_int));
    check("int_overrun", int'(int_overrun), int'(m_ovr));
    check("tic_count", int'(tic_count), m_d[0] - m_k[0]);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it
  task automatic step(input bit se, input bit ld, input bit clr, input int td, input int ad);
    sample_en = se; cfg_load = ld; int_clear = clr;
    tic_divide = TW'(td); accum_divide = AW'(ad);
    @(posedge gps_rec_clk);
    model_edge(se, ld, clr, td, ad);
    #1;
    check_model();
  endtask

  typedef struct {
    bit se; bit ld; bit clr; int td; int ad;
    bit e_tic; bit e_acc; bit e_int; bit e_ovr; int e_cnt;
  } vec_t;
  vec_t vt[9];

  int n_tic, n_acc, first_acc, prev_cnt, waited;

  initial begin
    // Hand-derived vectors: load tic=2 acc=1, then stepping, clear overlap,
    // then a load that lands on a zero count with a sample
    vt[0] = '{0,1,0,2,1, 0,0,0,0,2};
    vt[1] = '{1,0,0,0,0, 0,0,0,0,1};
    vt[2] = '{1,0,0,0,0, 0,1,0,0,0};
    vt[3] = '{1,0,0,0,0, 1,0,1,0,2};
    vt[4] = '{0,0,0,0,0, 0,0,1,0,2};
    vt[5] = '{1,0,0,0,0, 0,1,1,0,1};
    vt[6] = '{1,0,1,0,0, 0,0,1,0,0};
    vt[7] = '{0,0,1,0,0, 0,0,0,0,0};
    vt[8] = '{1,1,0,4,5, 0,0,0,0,4};

    model_reset();
    repeat (2) @(posedge gps_rec_clk);
    #1;
    check_model();
    sys_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vt[i].se, vt[i].ld, vt[i].clr, vt[i].td, vt[i].ad);
      check($sformatf("vec%0d_tic", i), int'(tic_enable), int'(vt[i].e_tic));
      check($sformatf("vec%0d_acc", i), int'(accum_enable), int'(vt[i].e_acc));
      check($sformatf("vec%0d_int", i), int'(accum_int), int'(vt[i].e_int & INT_ON));
      check($sformatf("vec%0d_ovr", i), int'(int_overrun), int'(vt[i].e_ovr & INT_ON));
      check($sformatf("vec%0d_cnt", i), int'(tic_count), vt[i].e_cnt);
    end

    // Continuous samples, acc=3, tic=9
    step(1, 1, 0, 9, 3);
    n_tic = 0; n_acc = 0; first_acc = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0, 0, 0);
      if (tic_enable) n_tic++;
      if (accum_enable) begin
        n_acc++;
        if (first_acc < 0) first_acc = i;
      end
    end
    check("cont_acc_pulses", n_acc, 10);
    check("cont_tic_pulses", n_tic, 4);
    check("cont_first_acc", first_acc, 4);

    // Sample every 3rd cycle, acc=1: one dump per 6 cycles, count holds between
    step(0, 1, 0, 9, 1);
    n_acc = 0;
    for (int i = 0; i < 60; i++) begin
      prev_cnt = int'(tic_count);
      step(i % 3 == 0, 0, 0, 0, 0);
      if (accum_enable) n_acc++;
      if (i % 3 != 0) check("hold_tic_count", int'(tic_count), prev_cnt);
    end
    check("third_acc_pulses", n_acc, 10);

    // Divider 0 back-to-back dumps, flags and overrun
    step(0, 1, 1, 5, 0);
    step(0, 0, 1, 0, 0);
    check("flags_cleared", int'(accum_int) + int'(int_overrun), 0);
    step(1, 0, 0, 0, 0);
    check("d0_acc1", int'(accum_enable), 1);
    check("d0_int1", int'(accum_int), 0);
    step(1, 0, 0, 0, 0);
    check("d0_acc2", int'(accum_enable), 1);
    check("d0_int2", int'(accum_int), int'(INT_ON));
    check("d0_ovr2", int'(int_overrun), 0);
    step(1, 0, 0, 0, 0);
    check("d0_ovr3", int'(int_overrun), int'(INT_ON));
    // Clear coinciding with a dump, then clear alone
    step(1, 0, 1, 0, 0);
    check("clr_dump_int", int'(accum_int), int'(INT_ON));
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("clr_alone", int'(accum_int) + int'(int_overrun), 0);

    // Load on a zero count with a sample: no pulse, new period follows
    step(0, 1, 0, 2, 2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 3, 3);
    check("ld_zero_tic", int'(tic_enable), 0);
    check("ld_zero_acc", int'(accum_enable), 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 0);
      check($sformatf("ld_zero_acc_s%0d", i), int'(accum_enable), int'(i == 4));
    end

    // Asynchronous reset in the middle of a pulse
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    sample_en = 1'b0; cfg_load = 1'b0; int_clear = 1'b0;
    @(posedge gps_rec_clk);
    #1;
    sys_rst_n = 1'b1;
    waited = 0;
    first_acc = -1;
    while (first_acc < 0 && waited < 300) begin
      step(1, 0, 0, 0, 0);
      waited++;
      if (accum_enable) first_acc = waited;
    end
    check("rst_first_acc", first_acc, 1 << AW);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_namuru_time_base
